// File: rtl/rijndael_pkg.sv
// Shared Rijndael helpers: block-size constants, ShiftRows row offsets and
// byte-to-bit-position mapping for the column-major state layout.
package rijndael_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  // Row rotation amount Cr; 256-bit blocks use 1,3,4 instead of 1,2,3.
  function automatic int shift_offset(input int nb, input int row);
    int off;
    case (row)
      0:       off = 0;
      1:       off = 1;
      2:       off = (nb == NB_256) ? 3 : 2;
      3:       off = (nb == NB_256) ? 4 : 3;
      default: off = 0;
    endcase
    return off;
  endfunction

  // Low bit of state byte s[r][c]; byte 0 sits in the top byte of the word.
  function automatic int byte_pos(input int r, input int c, input int nb);
    return (32 * nb) - 8 - (8 * ((4 * c) + r));
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB columns.
// Pure wiring; shared by the round, key-schedule and decrypt datapaths.
module shift_rows_perm
  import rijndael_pkg::*;
#(
  parameter int NB = NB_128,
  localparam int W = 32 * NB
) (
  input  logic [W-1:0] data_in,
  input  logic         inv,
  output logic [W-1:0] data_out
);

  logic [W-1:0] fwdData_s;
  logic [W-1:0] invData_s;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int CR    = shift_offset(NB, r);
      localparam int SRC_F = (c + CR) % NB;
      localparam int SRC_I = (c - CR + NB) % NB;
      assign fwdData_s[byte_pos(r, c, NB) +: 8] = data_in[byte_pos(r, SRC_F, NB) +: 8];
      assign invData_s[byte_pos(r, c, NB) +: 8] = data_in[byte_pos(r, SRC_I, NB) +: 8];
    end
  end

  assign data_out = inv ? invData_s : fwdData_s;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows engine: permutes on the input side and buffers results
// in a DEPTH-entry output FIFO. Define SHIFT_ROWS_PIPE_STATS_EN for counters.
module shift_rows_pipe
  import rijndael_pkg::*;
#(
  parameter int NB = NB_128,
  parameter int DEPTH = 2,
  localparam int W = 32 * NB,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_inv,
  output logic [LW-1:0] level
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  ,
  output logic [31:0]   xfer_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [DEPTH-1:0] memInv_r;
  logic [AW:0]      wrPtr_r;
  logic [AW:0]      rdPtr_r;
  logic [AW:0]      wrPtrNext_s;
  logic [AW:0]      rdPtrNext_s;
  logic [LW-1:0]    levelNext_s;
  logic [W-1:0]     shifted_s;
  logic             push_s;
  logic             pop_s;

  shift_rows_perm #(.NB(NB)) u_perm (
    .data_in  (in_data),
    .inv      (in_inv),
    .data_out (shifted_s)
  );

  assign push_s = in_valid & in_ready;
  assign pop_s  = out_valid & out_ready;

  // Next pointer values; a flush overrides any push or pop this cycle.
  always_comb begin
    wrPtrNext_s = wrPtr_r;
    rdPtrNext_s = rdPtr_r;
    if (clr) begin
      wrPtrNext_s = '0;
      rdPtrNext_s = '0;
    end else begin
      wrPtrNext_s = wrPtr_r + {{AW{1'b0}}, push_s};
      rdPtrNext_s = rdPtr_r + {{AW{1'b0}}, pop_s};
    end
  end

  assign levelNext_s = wrPtrNext_s - rdPtrNext_s;

  // Pointers, occupancy and registered flow-control flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r   <= '0;
      rdPtr_r   <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      wrPtr_r   <= wrPtrNext_s;
      rdPtr_r   <= rdPtrNext_s;
      level     <= levelNext_s;
      out_valid <= (levelNext_s != {LW{1'b0}});
      in_ready  <= (levelNext_s != DEPTH_L);
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      memInv_r <= '0;
    end else if (push_s && !clr) begin
      mem_r[wrPtr_r[AW-1:0]]    <= shifted_s;
      memInv_r[wrPtr_r[AW-1:0]] <= in_inv;
    end
  end

  assign out_data = mem_r[rdPtr_r[AW-1:0]];
  assign out_inv  = memInv_r[rdPtr_r[AW-1:0]];

`ifdef SHIFT_ROWS_PIPE_STATS_EN
  // Transfer counter wraps; stall counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (clr) begin
      xfer_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (pop_s) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB = 4, 6, 8 instances, DEPTH = 2,
// known vectors, back-pressure, flush, async reset and randomized streaming.
module tb_shift_rows_pipe;

  localparam int NWORDS = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         inValid [3];
  logic         inInv [3];
  logic         outReady [3];
  logic         inReady [3];
  logic         outValid [3];
  logic         outInv [3];
  logic [255:0] inData [3];
  logic [1:0]   lvl [3];
  logic [127:0] od4;
  logic [191:0] od6;
  logic [255:0] od8;
  logic [31:0]  xc [3];
  logic [31:0]  sc [3];

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .DEPTH(2)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0][127:0]),
    .in_inv(inInv[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(od4), .out_inv(outInv[0]), .level(lvl[0])
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    , .xfer_cnt(xc[0]), .stall_cnt(sc[0])
`endif
  );

  shift_rows_pipe #(.NB(6), .DEPTH(2)) u6 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1][191:0]),
    .in_inv(inInv[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(od6), .out_inv(outInv[1]), .level(lvl[1])
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    , .xfer_cnt(xc[1]), .stall_cnt(sc[1])
`endif
  );

  shift_rows_pipe #(.NB(8), .DEPTH(2)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
    .in_inv(inInv[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_data(od8), .out_inv(outInv[2]), .level(lvl[2])
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    , .xfer_cnt(xc[2]), .stall_cnt(sc[2])
`endif
  );

  function automatic logic [255:0] getOut(input int idx);
    case (idx)
      0:       return {128'd0, od4};
      1:       return {64'd0, od6};
      default: return od8;
    endcase
  endfunction

  // Reference: rebuild the state matrix byte by byte and rotate each row.
  function automatic logic [255:0] refShift(input logic [255:0] d, input int nb, input logic inv);
    logic [7:0]   b [32];
    logic [255:0] o;
    int w, r, c, cr, src;
    w = 32 * nb;
    o = '0;
    for (int k = 0; k < 4 * nb; k++) b[k] = d[w - 8 - 8 * k +: 8];
    for (int k = 0; k < 4 * nb; k++) begin
      r = k % 4;
      c = k / 4;
      if (r == 0) cr = 0;
      else if (nb == 8 && r >= 2) cr = r + 1;
      else cr = r;
      src = inv ? (c - cr + nb) % nb : (c + cr) % nb;
      o[w - 8 - 8 * k +: 8] = b[src * 4 + r];
    end
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic sendWord(input int idx, input logic [255:0] d, input logic inv);
    @(negedge clk);
    inValid[idx] = 1'b1;
    inData[idx]  = d;
    inInv[idx]   = inv;
    @(negedge clk);
    inValid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      nVec++;
      if (outValid[i] !== 1'b0 || inReady[i] !== 1'b0 || lvl[i] !== 2'd0 || getOut(i) !== 256'd0) begin
        nErr++;
        $display("FAIL reset_state dut%0d: out_valid=%b in_ready=%b level=%0d out_data=%h, need 0 0 0 0",
                 i, outValid[i], inReady[i], lvl[i], getOut(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nVec++;
    if (inReady[0] !== 1'b0) begin
      nErr++;
      $display("FAIL in_ready_before_edge: got %b need 0", inReady[0]);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nVec++;
      if (inReady[i] !== 1'b1) begin
        nErr++;
        $display("FAIL in_ready_after_edge dut%0d: got %b need 1", i, inReady[i]);
      end
    end
  endtask

  task automatic test_vector(input int idx, input logic [255:0] d, input logic inv,
                             input logic [255:0] exp, input string name);
    outReady[idx] = 1'b1;
    sendWord(idx, d, inv);
    nVec++;
    if (outValid[idx] !== 1'b1 || getOut(idx) !== exp || outInv[idx] !== inv) begin
      nErr++;
      $display("FAIL %s: valid=%b data=%h inv=%b, need 1 %h %b", name, outValid[idx], getOut(idx), outInv[idx], exp, inv);
    end
    @(negedge clk);
    nVec++;
    if (outValid[idx] !== 1'b0) begin
      nErr++;
      $display("FAIL %s_drain: out_valid=%b need 0", name, outValid[idx]);
    end
    outReady[idx] = 1'b0;
  endtask

  task automatic test_nb8();
    logic [255:0] d, res;
    for (int k = 0; k < 32; k++) d[255 - 8 * k -: 8] = k[7:0];
    outReady[2] = 1'b1;
    sendWord(2, d, 1'b0);
    res = od8;
    nVec++;
    if (res[255:224] !== 32'h00050e13 || res[31:0] !== 32'h1c010a0f || outValid[2] !== 1'b1) begin
      nErr++;
      $display("FAIL nb8_fwd_cols: col0=%h col7=%h valid=%b, need 00050e13 1c010a0f 1", res[255:224], res[31:0], outValid[2]);
    end
    nVec++;
    if (res !== refShift(d, 8, 1'b0)) begin
      nErr++;
      $display("FAIL nb8_fwd_full: got %h need %h", res, refShift(d, 8, 1'b0));
    end
    @(negedge clk);
    test_vector(2, res, 1'b1, d, "nb8_inv_roundtrip");
  endtask

  task automatic test_back_pressure();
    logic [255:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = rnd256();
    outReady[0] = 1'b0;
    @(negedge clk);
    inValid[0] = 1'b1; inData[0] = w[0]; inInv[0] = 1'b0;
    @(negedge clk);
    nVec++;
    if (inReady[0] !== 1'b1 || lvl[0] !== 2'd1) begin
      nErr++;
      $display("FAIL bp_one: in_ready=%b level=%0d need 1 1", inReady[0], lvl[0]);
    end
    inData[0] = w[1]; inInv[0] = 1'b1;
    @(negedge clk);
    nVec++;
    if (inReady[0] !== 1'b0 || lvl[0] !== 2'd2 || getOut(0) !== refShift(w[0], 4, 1'b0)) begin
      nErr++;
      $display("FAIL bp_full: in_ready=%b level=%0d data=%h, need 0 2 %h", inReady[0], lvl[0], getOut(0), refShift(w[0], 4, 1'b0));
    end
    inData[0] = w[2]; inInv[0] = 1'b0;
    @(negedge clk);
    nVec++;
    if (inReady[0] !== 1'b0 || lvl[0] !== 2'd2 || outValid[0] !== 1'b1 || getOut(0) !== refShift(w[0], 4, 1'b0) || outInv[0] !== 1'b0) begin
      nErr++;
      $display("FAIL bp_hold: in_ready=%b level=%0d valid=%b data=%h inv=%b", inReady[0], lvl[0], outValid[0], getOut(0), outInv[0]);
    end
    outReady[0] = 1'b1;
    @(negedge clk);
    nVec++;
    if (lvl[0] !== 2'd1 || inReady[0] !== 1'b1 || getOut(0) !== refShift(w[1], 4, 1'b1) || outInv[0] !== 1'b1) begin
      nErr++;
      $display("FAIL bp_pop1: level=%0d in_ready=%b data=%h inv=%b, need 1 1 %h 1", lvl[0], inReady[0], getOut(0), outInv[0], refShift(w[1], 4, 1'b1));
    end
    @(negedge clk);
    inValid[0] = 1'b0;
    nVec++;
    if (lvl[0] !== 2'd1 || getOut(0) !== refShift(w[2], 4, 1'b0) || outInv[0] !== 1'b0) begin
      nErr++;
      $display("FAIL bp_pop2: level=%0d data=%h inv=%b, need 1 %h 0", lvl[0], getOut(0), outInv[0], refShift(w[2], 4, 1'b0));
    end
    @(negedge clk);
    nVec++;
    if (outValid[0] !== 1'b0 || lvl[0] !== 2'd0) begin
      nErr++;
      $display("FAIL bp_empty: valid=%b level=%0d need 0 0", outValid[0], lvl[0]);
    end
    outReady[0] = 1'b0;
  endtask

  task automatic fillTwo();
    outReady[0] = 1'b0;
    @(negedge clk);
    inValid[0] = 1'b1; inData[0] = rnd256(); inInv[0] = 1'b1;
    @(negedge clk);
    inData[0] = rnd256();
    @(negedge clk);
    inValid[0] = 1'b0;
    nVec++;
    if (lvl[0] !== 2'd2) begin
      nErr++;
      $display("FAIL fill_level: got %0d need 2", lvl[0]);
    end
  endtask

  task automatic test_flush();
    fillTwo();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    nVec++;
    if (outValid[0] !== 1'b0 || lvl[0] !== 2'd0 || inReady[0] !== 1'b1) begin
      nErr++;
      $display("FAIL flush: valid=%b level=%0d in_ready=%b need 0 0 1", outValid[0], lvl[0], inReady[0]);
    end
  endtask

  task automatic test_async_reset();
    fillTwo();
    #2 rst_n = 1'b0;
    #1;
    nVec++;
    if (outValid[0] !== 1'b0 || getOut(0) !== 256'd0 || lvl[0] !== 2'd0 || inReady[0] !== 1'b0) begin
      nErr++;
      $display("FAIL async_reset: valid=%b data=%h level=%0d in_ready=%b need 0 0 0 0", outValid[0], getOut(0), lvl[0], inReady[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nVec++;
    if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0) begin
      nErr++;
      $display("FAIL post_reset: in_ready=%b valid=%b need 1 0", inReady[0], outValid[0]);
    end
  endtask

  task automatic test_streaming(input int idx, input int nb);
    logic [255:0] qd [$];
    logic         qi [$];
    logic [255:0] d;
    int sent, rcvd;
    sent = 0;
    rcvd = 0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int cyc = 0; cyc < 20000 && rcvd < NWORDS; cyc++) begin
      @(negedge clk);
      nVec++;
      if (lvl[idx] !== 2'(qd.size()) || inReady[idx] !== (qd.size() < 2) || outValid[idx] !== (qd.size() != 0)) begin
        nErr++;
        $display("FAIL stream_flags nb%0d: level=%0d in_ready=%b valid=%b, model size %0d", nb, lvl[idx], inReady[idx], outValid[idx], qd.size());
      end
      inValid[idx]  = (sent < NWORDS) && ($urandom_range(0, 3) != 0);
      outReady[idx] = ($urandom_range(0, 3) != 0);
      d = rnd256();
      inData[idx] = d;
      inInv[idx]  = 1'($urandom_range(0, 1));
      if (outValid[idx] && outReady[idx] && qd.size() != 0) begin
        nVec++;
        if (getOut(idx) !== qd[0] || outInv[idx] !== qi[0]) begin
          nErr++;
          $display("FAIL stream_data nb%0d word %0d: got %h/%b need %h/%b", nb, rcvd, getOut(idx), outInv[idx], qd[0], qi[0]);
        end
        void'(qd.pop_front());
        void'(qi.pop_front());
        rcvd++;
      end
      if (inValid[idx] && inReady[idx]) begin
        qd.push_back(refShift(d, nb, inInv[idx]));
        qi.push_back(inInv[idx]);
        sent++;
      end
    end
    @(negedge clk);
    inValid[idx]  = 1'b0;
    outReady[idx] = 1'b0;
    nVec++;
    if (rcvd != NWORDS) begin
      nErr++;
      $display("FAIL stream_timeout nb%0d: received %0d need %0d", nb, rcvd, NWORDS);
    end
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    nVec++;
    if (xc[idx] !== 32'(NWORDS)) begin
      nErr++;
      $display("FAIL xfer_cnt nb%0d: got %0d need %0d", nb, xc[idx], NWORDS);
    end
`endif
  endtask

  initial begin
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid[i] = 1'b0; inInv[i] = 1'b0; outReady[i] = 1'b0; inData[i] = '0;
    end
    test_reset();
    test_vector(0, 256'h63cab7040953d051cd60e0e7ba70e18c, 1'b0, 256'h6353e08c0960e104cd70b751bacad0e7, "fwd_nb4");
    test_vector(0, 256'h6353e08c0960e104cd70b751bacad0e7, 1'b1, 256'h63cab7040953d051cd60e0e7ba70e18c, "inv_nb4");
    begin
      logic [255:0] r6;
      r6 = rnd256();
      test_vector(1, r6, 1'b0, refShift(r6, 6, 1'b0), "fwd_nb6");
      test_vector(1, r6, 1'b1, refShift(r6, 6, 1'b1), "inv_nb6");
    end
    test_nb8();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_streaming(0, 4);
    test_streaming(1, 6);
    test_streaming(2, 8);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
